// File: rtl/tl_width_widget_down.sv
// TileLink width adapter: splits wide inner A beats into narrow outer beats and
// merges outer D beats back into wide inner beats. Define TLWW_ASSERT_EN for simulation checks.
module tl_width_widget_down #(
  parameter int IN_BYTES  = 8,
  parameter int OUT_BYTES = 4,
  parameter int ADDR_W    = 32,
  parameter int SOURCE_W  = 4,
  parameter int SIZE_W    = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  // inner A
  output logic                    auto_in_a_ready,
  input  logic                    auto_in_a_valid,
  input  logic [2:0]              auto_in_a_opcode,
  input  logic [2:0]              auto_in_a_param,
  input  logic [SIZE_W-1:0]       auto_in_a_size,
  input  logic [SOURCE_W-1:0]     auto_in_a_source,
  input  logic [ADDR_W-1:0]       auto_in_a_address,
  input  logic [IN_BYTES-1:0]     auto_in_a_mask,
  input  logic [8*IN_BYTES-1:0]   auto_in_a_data,
  input  logic                    auto_in_a_corrupt,
  // inner D
  input  logic                    auto_in_d_ready,
  output logic                    auto_in_d_valid,
  output logic [2:0]              auto_in_d_opcode,
  output logic [SIZE_W-1:0]       auto_in_d_size,
  output logic [SOURCE_W-1:0]     auto_in_d_source,
  output logic                    auto_in_d_denied,
  output logic [8*IN_BYTES-1:0]   auto_in_d_data,
  output logic                    auto_in_d_corrupt,
  // outer A
  input  logic                    auto_out_a_ready,
  output logic                    auto_out_a_valid,
  output logic [2:0]              auto_out_a_opcode,
  output logic [2:0]              auto_out_a_param,
  output logic [SIZE_W-1:0]       auto_out_a_size,
  output logic [SOURCE_W-1:0]     auto_out_a_source,
  output logic [ADDR_W-1:0]       auto_out_a_address,
  output logic [OUT_BYTES-1:0]    auto_out_a_mask,
  output logic [8*OUT_BYTES-1:0]  auto_out_a_data,
  output logic                    auto_out_a_corrupt,
  // outer D
  output logic                    auto_out_d_ready,
  input  logic                    auto_out_d_valid,
  input  logic [2:0]              auto_out_d_opcode,
  input  logic [SIZE_W-1:0]       auto_out_d_size,
  input  logic [SOURCE_W-1:0]     auto_out_d_source,
  input  logic                    auto_out_d_denied,
  input  logic [8*OUT_BYTES-1:0]  auto_out_d_data,
  input  logic                    auto_out_d_corrupt
);

  localparam int RATIO  = IN_BYTES / OUT_BYTES;
  localparam int LO     = $clog2(OUT_BYTES);
  localparam int HI     = $clog2(IN_BYTES);
  localparam int LANE_W = HI - LO;
  localparam int OW     = 8 * OUT_BYTES;

  localparam logic [SIZE_W-1:0] LO_SZ     = SIZE_W'(LO);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  localparam logic [2:0] OP_PUT_FULL     = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL  = 3'd1;
  localparam logic [2:0] OP_ACCESS_DATA  = 3'd1;

  logic [LANE_W-1:0]         a_cnt;
  logic [LANE_W-1:0]         d_cnt;
  logic [(RATIO-1)*OW-1:0]   d_buf;
  logic                      den_acc;
  logic                      cor_acc;

  logic                      a_wide, a_split, a_fire;
  logic [LANE_W-1:0]         a_lane;
  logic [OUT_BYTES-1:0]      lane_mask;
  logic                      d_merge, d_last, d_fire;

  assign a_wide  = auto_in_a_size > LO_SZ;
  assign a_split = a_wide && (auto_in_a_opcode == OP_PUT_FULL || auto_in_a_opcode == OP_PUT_PARTIAL);
  assign a_fire  = auto_in_a_valid && auto_out_a_ready;

  assign auto_out_a_valid   = auto_in_a_valid;
  assign auto_out_a_opcode  = auto_in_a_opcode;
  assign auto_out_a_param   = auto_in_a_param;
  assign auto_out_a_size    = auto_in_a_size;
  assign auto_out_a_source  = auto_in_a_source;
  assign auto_out_a_address = auto_in_a_address;
  assign auto_out_a_corrupt = auto_in_a_corrupt;
  assign auto_out_a_mask    = (a_wide && !a_split) ? '1 : lane_mask;
  // The inner beat is consumed only once its last lane has been accepted outside.
  assign auto_in_a_ready    = auto_out_a_ready && (!a_split || a_cnt == LAST_LANE);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    a_lane          = a_split ? a_cnt : (a_wide ? '0 : auto_in_a_address[HI-1:LO]);
    auto_out_a_data = '0;
    lane_mask       = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (a_lane == LANE_W'(i)) begin
        auto_out_a_data = auto_in_a_data[i*OW +: OW];
        lane_mask       = auto_in_a_mask[i*OUT_BYTES +: OUT_BYTES];
      end
    end
  end

  // Only wide AccessAckData is merged; a wide AccessAck carries no data.
  assign d_merge = (auto_out_d_size > LO_SZ) && (auto_out_d_opcode == OP_ACCESS_DATA);
  assign d_last  = d_cnt == LAST_LANE;
  assign d_fire  = auto_out_d_valid && auto_out_d_ready;

  assign auto_in_d_opcode = auto_out_d_opcode;
  assign auto_in_d_size   = auto_out_d_size;
  assign auto_in_d_source = auto_out_d_source;

  always_comb begin
    auto_in_d_valid   = auto_out_d_valid;
    auto_out_d_ready  = auto_in_d_ready;
    auto_in_d_data    = {RATIO{auto_out_d_data}};
    auto_in_d_denied  = auto_out_d_denied;
    auto_in_d_corrupt = auto_out_d_corrupt;
    if (d_merge) begin
      if (!d_last) begin
        auto_in_d_valid  = 1'b0;
        auto_out_d_ready = 1'b1;
      end else begin
        auto_in_d_data    = {auto_out_d_data, d_buf};
        auto_in_d_denied  = auto_out_d_denied  | den_acc;
        auto_in_d_corrupt = auto_out_d_corrupt | cor_acc;
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_cnt   <= '0;
      d_cnt   <= '0;
      // NOTE: the merge buffer is small and explicitly cleared, so a reset never exposes stale lanes.
      d_buf   <= '0;
      den_acc <= 1'b0;
      cor_acc <= 1'b0;
    end else begin
      if (a_fire && a_split) a_cnt <= a_cnt + LANE_W'(1);
      if (d_fire && d_merge) begin
        d_cnt <= d_cnt + LANE_W'(1);
        if (d_last) begin
          den_acc <= 1'b0;
          cor_acc <= 1'b0;
        end else begin
          den_acc <= den_acc | auto_out_d_denied;
          cor_acc <= cor_acc | auto_out_d_corrupt;
          for (int i = 0; i < RATIO - 1; i++) begin
            if (d_cnt == LANE_W'(i)) d_buf[i*OW +: OW] <= auto_out_d_data;
          end
        end
      end
    end
  end

`ifdef TLWW_ASSERT_EN
  localparam int A_FW = 7 + SIZE_W + SOURCE_W + ADDR_W + IN_BYTES + 8*IN_BYTES;
  localparam int D_FW = 3 + SIZE_W + SOURCE_W;
  localparam logic [SIZE_W-1:0] HI_SZ = SIZE_W'(HI);

  logic [A_FW-1:0] a_fields, a_hold;
  logic [D_FW-1:0] d_fields, d_hold;

  assign a_fields = {auto_in_a_opcode, auto_in_a_param, auto_in_a_size, auto_in_a_source,
                     auto_in_a_address, auto_in_a_mask, auto_in_a_data, auto_in_a_corrupt};
  assign d_fields = {auto_out_d_opcode, auto_out_d_size, auto_out_d_source};

  always_ff @(posedge clock) begin
    if (a_fire && a_split) a_hold <= a_fields;
    if (d_fire && d_merge) d_hold <= d_fields;
    if (!reset) begin
      if (auto_in_a_valid && a_cnt != '0)
        assert (a_fields == a_hold) else $error("inner A changed mid-split");
      if (auto_out_d_valid && d_cnt != '0)
        assert (d_fields == d_hold) else $error("outer D header changed mid-merge");
      if (auto_in_a_valid)
        assert (auto_in_a_size <= HI_SZ) else $error("A size exceeds inner width");
      if (auto_out_d_valid)
        assert (auto_out_d_size <= HI_SZ) else $error("D size exceeds inner width");
    end
  end
`endif

endmodule

// File: tb/tb_tl_width_widget_down.sv
// Directed bench for tl_width_widget_down (8-byte inner, 4-byte outer): table-driven
// A vectors plus hand-written D merge, backpressure, accumulation and reset sequences.
module tb_tl_width_widget_down;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_a_ready, in_a_valid, in_a_corrupt;
  logic [2:0]  in_a_opcode, in_a_param, in_a_size;
  logic [3:0]  in_a_source;
  logic [31:0] in_a_address;
  logic [7:0]  in_a_mask;
  logic [63:0] in_a_data;
  logic        in_d_ready, in_d_valid, in_d_denied, in_d_corrupt;
  logic [2:0]  in_d_opcode, in_d_size;
  logic [3:0]  in_d_source;
  logic [63:0] in_d_data;
  logic        out_a_ready, out_a_valid, out_a_corrupt;
  logic [2:0]  out_a_opcode, out_a_param, out_a_size;
  logic [3:0]  out_a_source;
  logic [31:0] out_a_address;
  logic [3:0]  out_a_mask;
  logic [31:0] out_a_data;
  logic        out_d_ready, out_d_valid, out_d_denied, out_d_corrupt;
  logic [2:0]  out_d_opcode, out_d_size;
  logic [3:0]  out_d_source;
  logic [31:0] out_d_data;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  tl_width_widget_down dut (
    .clock(clock), .reset(reset),
    .auto_in_a_ready(in_a_ready), .auto_in_a_valid(in_a_valid), .auto_in_a_opcode(in_a_opcode),
    .auto_in_a_param(in_a_param), .auto_in_a_size(in_a_size), .auto_in_a_source(in_a_source),
    .auto_in_a_address(in_a_address), .auto_in_a_mask(in_a_mask), .auto_in_a_data(in_a_data),
    .auto_in_a_corrupt(in_a_corrupt),
    .auto_in_d_ready(in_d_ready), .auto_in_d_valid(in_d_valid), .auto_in_d_opcode(in_d_opcode),
    .auto_in_d_size(in_d_size), .auto_in_d_source(in_d_source), .auto_in_d_denied(in_d_denied),
    .auto_in_d_data(in_d_data), .auto_in_d_corrupt(in_d_corrupt),
    .auto_out_a_ready(out_a_ready), .auto_out_a_valid(out_a_valid), .auto_out_a_opcode(out_a_opcode),
    .auto_out_a_param(out_a_param), .auto_out_a_size(out_a_size), .auto_out_a_source(out_a_source),
    .auto_out_a_address(out_a_address), .auto_out_a_mask(out_a_mask), .auto_out_a_data(out_a_data),
    .auto_out_a_corrupt(out_a_corrupt),
    .auto_out_d_ready(out_d_ready), .auto_out_d_valid(out_d_valid), .auto_out_d_opcode(out_d_opcode),
    .auto_out_d_size(out_d_size), .auto_out_d_source(out_d_source), .auto_out_d_denied(out_d_denied),
    .auto_out_d_data(out_d_data), .auto_out_d_corrupt(out_d_corrupt)
  );

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [7:0]  mask;
    logic [63:0] data;
    logic        oready;
    logic [31:0] exp_data;
    logic [3:0]  exp_mask;
    logic        exp_iready;
  } a_vec_t;

  a_vec_t a_vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [2:0] size, input logic [31:0] addr,
                         input logic [7:0] mask, input logic [63:0] data, input logic oready);
    in_a_valid   = 1'b1;
    in_a_opcode  = op;
    in_a_size    = size;
    in_a_address = addr;
    in_a_mask    = mask;
    in_a_data    = data;
    out_a_ready  = oready;
  endtask

  task automatic drive_d(input logic [2:0] op, input logic [2:0] size, input logic [31:0] data,
                         input logic denied, input logic corrupt, input logic iready);
    out_d_valid   = 1'b1;
    out_d_opcode  = op;
    out_d_size    = size;
    out_d_data    = data;
    out_d_denied  = denied;
    out_d_corrupt = corrupt;
    in_d_ready    = iready;
  endtask

  initial begin
    a_vecs[0] = '{3'd0, 3'd2, 32'h1004, 8'hA5, 64'hAAAABBBB_CCCCDDDD, 1'b1, 32'hAAAABBBB, 4'hA, 1'b1};
    a_vecs[1] = '{3'd0, 3'd2, 32'h1000, 8'hA5, 64'hAAAABBBB_CCCCDDDD, 1'b1, 32'hCCCCDDDD, 4'h5, 1'b1};
    a_vecs[2] = '{3'd1, 3'd1, 32'h2006, 8'hC0, 64'h01234567_89ABCDEF, 1'b1, 32'h01234567, 4'hC, 1'b1};
    a_vecs[3] = '{3'd4, 3'd3, 32'h3000, 8'hFF, 64'h0,                 1'b1, 32'h00000000, 4'hF, 1'b1};
    a_vecs[4] = '{3'd0, 3'd3, 32'h4000, 8'hFF, 64'h11223344_55667788, 1'b0, 32'h55667788, 4'hF, 1'b0};
    a_vecs[5] = '{3'd0, 3'd3, 32'h4000, 8'hFF, 64'h11223344_55667788, 1'b1, 32'h55667788, 4'hF, 1'b0};
    a_vecs[6] = '{3'd0, 3'd3, 32'h4000, 8'hFF, 64'h11223344_55667788, 1'b1, 32'h11223344, 4'hF, 1'b1};
    a_vecs[7] = '{3'd4, 3'd0, 32'h0005, 8'h02, 64'h01234567_89ABCDEF, 1'b0, 32'h01234567, 4'h0, 1'b0};

    reset        = 1'b1;
    in_a_valid   = 1'b0;
    in_a_opcode  = 3'd0;
    in_a_param   = 3'd2;
    in_a_size    = 3'd0;
    in_a_source  = 4'h9;
    in_a_address = 32'h0;
    in_a_mask    = 8'h0;
    in_a_data    = 64'h0;
    in_a_corrupt = 1'b0;
    out_a_ready  = 1'b0;
    out_d_valid  = 1'b0;
    out_d_opcode = 3'd0;
    out_d_size   = 3'd0;
    out_d_source = 4'h3;
    out_d_data   = 32'h0;
    out_d_denied = 1'b0;
    out_d_corrupt = 1'b0;
    in_d_ready   = 1'b0;

    // During reset outputs stay combinational: narrow A passes ready, wide Put waits on lane 1.
    tick();
    drive_a(3'd0, 3'd2, 32'h1004, 8'hF0, 64'h0, 1'b1);
    #2 check("rst_narrow_ready", in_a_ready, 1'b1);
    drive_a(3'd0, 3'd3, 32'h0, 8'hFF, 64'h0, 1'b1);
    #2 check("rst_wide_ready", in_a_ready, 1'b0);
    check("rst_d_valid", in_d_valid, 1'b0);
    tick();
    reset = 1'b0;
    in_a_valid = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      drive_a(a_vecs[i].op, a_vecs[i].size, a_vecs[i].addr, a_vecs[i].mask, a_vecs[i].data,
              a_vecs[i].oready);
      in_a_corrupt = i[0];
      #2;
      check($sformatf("a%0d_data", i), out_a_data, a_vecs[i].exp_data);
      check($sformatf("a%0d_mask", i), out_a_mask, a_vecs[i].exp_mask);
      check($sformatf("a%0d_iready", i), in_a_ready, a_vecs[i].exp_iready);
      check($sformatf("a%0d_addr", i), out_a_address, a_vecs[i].addr);
      check($sformatf("a%0d_size", i), out_a_size, a_vecs[i].size);
      check($sformatf("a%0d_opcode", i), out_a_opcode, a_vecs[i].op);
      check($sformatf("a%0d_corrupt", i), out_a_corrupt, i[0]);
      tick();
    end
    check("a_valid_pass", out_a_valid, 1'b1);
    check("a_param_pass", out_a_param, 3'd2);
    check("a_source_pass", out_a_source, 4'h9);
    in_a_valid = 1'b0;
    in_a_corrupt = 1'b0;

    // Wide AccessAckData: the merged beat appears with the second outer beat.
    drive_d(3'd1, 3'd3, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
    #2 check("merge_l0_ivalid", in_d_valid, 1'b0);
    check("merge_l0_oready", out_d_ready, 1'b1);
    tick();
    drive_d(3'd1, 3'd3, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1);
    #2 check("merge_l1_ivalid", in_d_valid, 1'b1);
    check("merge_l1_data", in_d_data, 64'hCAFEF00D_DEADBEEF);
    check("merge_l1_oready", out_d_ready, 1'b1);
    check("merge_opcode", in_d_opcode, 3'd1);
    check("merge_source", in_d_source, 4'h3);
    tick();

    // Backpressure on the last lane holds the buffered lane.
    drive_d(3'd1, 3'd3, 32'h11111111, 1'b0, 1'b0, 1'b0);
    #2 check("bp_l0_oready", out_d_ready, 1'b1);
    tick();
    drive_d(3'd1, 3'd3, 32'h22222222, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #2;
      check($sformatf("bp_hold%0d_oready", c), out_d_ready, 1'b0);
      check($sformatf("bp_hold%0d_ivalid", c), in_d_valid, 1'b1);
      check($sformatf("bp_hold%0d_data", c), in_d_data, 64'h22222222_11111111);
      tick();
    end
    in_d_ready = 1'b1;
    #2 check("bp_release_oready", out_d_ready, 1'b1);
    check("bp_release_data", in_d_data, 64'h22222222_11111111);
    tick();

    // Corrupt and denied accumulate over the burst and clear afterwards.
    drive_d(3'd1, 3'd3, 32'h0A0A0A0A, 1'b1, 1'b1, 1'b1);
    tick();
    drive_d(3'd1, 3'd3, 32'h0B0B0B0B, 1'b0, 1'b0, 1'b1);
    #2 check("acc_corrupt", in_d_corrupt, 1'b1);
    check("acc_denied", in_d_denied, 1'b1);
    tick();
    drive_d(3'd1, 3'd3, 32'h0C0C0C0C, 1'b0, 1'b0, 1'b1);
    tick();
    drive_d(3'd1, 3'd3, 32'h0D0D0D0D, 1'b0, 1'b0, 1'b1);
    #2 check("clean_corrupt", in_d_corrupt, 1'b0);
    check("clean_denied", in_d_denied, 1'b0);
    check("clean_data", in_d_data, 64'h0D0D0D0D_0C0C0C0C);
    tick();

    // Wide AccessAck and narrow AccessAckData pass straight through, replicated.
    drive_d(3'd0, 3'd3, 32'h12345678, 1'b1, 1'b0, 1'b0);
    #2 check("ack_ivalid", in_d_valid, 1'b1);
    check("ack_oready", out_d_ready, 1'b0);
    check("ack_data", in_d_data, 64'h12345678_12345678);
    check("ack_denied", in_d_denied, 1'b1);
    tick();
    drive_d(3'd1, 3'd2, 32'h9ABCDEF0, 1'b0, 1'b1, 1'b1);
    #2 check("narrow_d_data", in_d_data, 64'h9ABCDEF0_9ABCDEF0);
    check("narrow_d_corrupt", in_d_corrupt, 1'b1);
    check("narrow_d_ivalid", in_d_valid, 1'b1);
    tick();

    // Reset mid-split and mid-merge restarts both counters at lane 0.
    drive_a(3'd0, 3'd3, 32'h4000, 8'hFF, 64'h11223344_55667788, 1'b1);
    drive_d(3'd1, 3'd3, 32'hAAAA5555, 1'b0, 1'b1, 1'b1);
    tick();
    in_a_valid  = 1'b0;
    out_d_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive_a(3'd1, 3'd3, 32'h5000, 8'h3C, 64'h77776666_55554444, 1'b1);
    drive_d(3'd1, 3'd3, 32'hBBBB0000, 1'b0, 1'b0, 1'b1);
    #2 check("rst_split_data", out_a_data, 32'h55554444);
    check("rst_split_mask", out_a_mask, 4'hC);
    check("rst_split_iready", in_a_ready, 1'b0);
    check("rst_merge_ivalid", in_d_valid, 1'b0);
    tick();
    out_d_data = 32'hCCCC1111;
    #2 check("rst_split_l1_data", out_a_data, 32'h77776666);
    check("rst_split_l1_mask", out_a_mask, 4'h3);
    check("rst_split_l1_iready", in_a_ready, 1'b1);
    check("rst_merge_l1_data", in_d_data, 64'hCCCC1111_BBBB0000);
    check("rst_merge_l1_corrupt", in_d_corrupt, 1'b0);
    tick();
    in_a_valid  = 1'b0;
    out_d_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tl_width_widget_down.md
TL_WIDTH_WIDGET_DOWN -- requirements
Module: tl_width_widget_down

Interface
REQ-001 SHALL have parameter IN_BYTES, default 8, meaning inner (auto_in) data bytes per beat.
REQ-002 SHALL have parameter OUT_BYTES, default 4, meaning outer (auto_out) data bytes per beat; RATIO = IN_BYTES/OUT_BYTES is a power of 2 and at least 2.
REQ-003 SHALL have parameters ADDR_W (default 32), SOURCE_W (default 4) and SIZE_W (default 3), meaning the widths of the address, source and size fields.
REQ-004 SHALL have port clock, input, 1 bit, meaning the single clock.
REQ-005 SHALL have port reset, input, 1 bit, meaning a synchronous, active-high reset.
REQ-006 SHALL have ports auto_in_a_*, meaning the inner A channel: ready out; valid, opcode[3], param[3], size, source, address, mask[IN_BYTES], data[8*IN_BYTES] and corrupt in.
REQ-007 SHALL have ports auto_in_d_*, meaning the inner D channel: ready in; valid, opcode[3], size, source, denied, data[8*IN_BYTES] and corrupt out.
REQ-008 SHALL have ports auto_out_a_* and auto_out_d_*, meaning the outer A and D channels; they carry the same fields as the inner channels with mask[OUT_BYTES] and data[8*OUT_BYTES].

Function
REQ-009 SHALL define LO = log2(OUT_BYTES) and HI = log2(IN_BYTES); an A or D beat is "wide" when its size > LO, otherwise "narrow".
REQ-010 SHALL pass opcode, param, size, source, address and corrupt combinationally from inner A to outer A, and opcode, size and source from outer D to inner D.
REQ-011 SHALL, for a narrow A beat, issue one outer beat whose data and mask are lane address[HI-1:LO] of the inner data and mask; auto_in_a_ready = auto_out_a_ready.
REQ-012 SHALL, for a wide Get (opcode 4), issue one outer beat with mask all-ones; auto_in_a_ready = auto_out_a_ready.
REQ-013 SHALL, for a wide Put (opcode 0 or 1), issue RATIO outer beats per inner beat, taking lanes 0..RATIO-1 in order from a lane counter.
REQ-014 SHALL, during a wide Put, advance the lane counter only on an outer A fire, and drive auto_in_a_ready = auto_out_a_ready AND (counter == RATIO-1); the counter SHALL wrap to 0 on the last lane.
REQ-015 SHALL, for a narrow D beat, replicate outer data into all RATIO inner lanes and pass valid, ready, denied and corrupt combinationally.
REQ-016 SHALL, for a wide AccessAckData (opcode 1), capture lanes 0..RATIO-2 into a buffer with auto_out_d_ready = 1 and auto_in_d_valid = 0.
REQ-017 SHALL, on the last D lane, drive auto_in_d_valid = auto_out_d_valid and auto_out_d_ready = auto_in_d_ready, with inner data = {current lane, buffered lanes}; this path adds no bubble.
REQ-018 SHALL present denied and corrupt on the last D lane as the OR of those flags over all RATIO lanes; the accumulators SHALL clear after the last lane fires.
REQ-019 SHALL treat a wide AccessAck (opcode 0) D beat as narrow.
REQ-020 SHALL have a latency of zero cycles on the A path and on the last D lane.

Reset
REQ-021 SHALL, while reset is high, clear the A lane counter, D lane counter, D buffer and denied/corrupt accumulators at the clock edge.
REQ-022 SHALL abandon any partially split or partially merged burst on a reset mid-burst, restarting at lane 0.
REQ-023 SHALL keep all outputs combinational, so they follow inputs and state during reset (auto_in_a_ready = auto_out_a_ready with counter 0).

Configuration
REQ-024 SHALL, with macro TLWW_ASSERT_EN defined, include simulation-only checks that report an error if any of the following occurs:
- inner A fields change while a wide Put is mid-split;
- outer D opcode, size or source changes mid-merge;
- a size > HI is seen.
REQ-025 SHALL, without TLWW_ASSERT_EN, contain no checking logic; data-path behaviour SHALL be identical with and without the macro.

Verification
REQ-026 Wide PutFull: size=3, data=0x1122334455667788, mask=0xFF -> two outer beats, 0x55667788/mask 0xF then 0x11223344/mask 0xF; auto_in_a_ready high only on the second beat.
REQ-027 Narrow Put: size=2, address=0x1004, data=0xAAAABBBB_CCCCDDDD -> one outer beat, data 0xAAAABBBB, mask = in_mask[7:4].
REQ-028 Wide AccessAckData: outer beats 0xDEADBEEF then 0xCAFEF00D -> one inner beat 0xCAFEF00D_DEADBEEF, presented in the same cycle as the second outer beat.
REQ-029 D backpressure: auto_in_d_ready=0 on the last lane for 3 cycles -> auto_out_d_ready=0 and the buffered lane is held; the beat completes when ready rises.
REQ-030 Corrupt accumulation: corrupt=1 on lane 0 only of a wide AccessAckData -> inner corrupt=1; the next burst with all lanes clean -> corrupt=0.
REQ-031 Reset mid-split after lane 0 of a wide Put -> the next Put starts at lane 0.
